instr_mem_responder: RTL
========================

Name: instr_mem_responder

Overview:
Instruction-memory responder serving the fetch stage's read requests over a valid/ready request and response handshake, with a fixed, parameterised access latency. It holds a word-addressed program store, which a program-load write port fills while the core is held off. It replaces the fetch stage's internal hard-wired ROM and sits between the fetch unit and the program loader.

Parameters:
DEPTH, 1024, number of 32-bit instruction words (power of 2, 16..4096)
LATENCY, 2, cycles from request acceptance to rsp_valid rising (legal 1..4)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address of requested instruction (PC)
rsp_valid  output  1  response present
rsp_ready  input  1  fetch unit consumes response this cycle
rsp_instr  output  32  fetched instruction word
rsp_err  output  1  request was misaligned or out of range
ld_we  input  1  program-load write strobe
ld_addr  input  log2(DEPTH)  word index for load write
ld_data  input  32  word to store
fetch_count  output  32  number of completed responses since reset

Behaviour:
- Reset (reset=0, async): state=IDLE; rsp_valid=0, rsp_instr=0, rsp_err=0, fetch_count=0, wait counter=0. Memory contents are NOT cleared.
- req_ready = 1 iff state==IDLE and reset deasserted; combinational from state only, with no dependence on req_valid.
- Accept: req_valid & req_ready on a rising edge. At acceptance:
  - word index = req_addr[log2(DEPTH)+1:2];
  - err = (req_addr[1:0]!=0) | (req_addr >= 4*DEPTH);
  - captured data = err ? 32'h0000_0000 : mem[index].
  - Data is sampled at accept. A load write to the same word on the same edge is NOT visible, so the old word is returned.
- States:
  - IDLE: on accept, go to RESP if LATENCY==1, else go to WAIT with counter=LATENCY-2.
  - WAIT: counter decrements each cycle. When counter==0, go to RESP next edge.
  - RESP: rsp_valid=1; rsp_instr/rsp_err hold captured values and are stable while rsp_valid & !rsp_ready. On rsp_ready, go to IDLE, rsp_valid=0 next cycle, fetch_count+1.
- Latency: rsp_valid rises exactly LATENCY cycles after the accept edge. Minimum issue interval is LATENCY+1 cycles, since a new accept is only possible after returning to IDLE. One outstanding request maximum.
- rsp_instr/rsp_err drive 0 when rsp_valid=0.
- Load port: ld_we writes mem[ld_addr]<=ld_data on a rising edge, in any state. Writes are ignored while reset=0.
- fetch_count wraps from 32'hFFFF_FFFF to 0. Error responses count.
- Reset mid-operation (WAIT or RESP): the pending response is dropped with no rsp_valid pulse, and the state returns to IDLE.
- rsp_ready while rsp_valid=0: ignored.

Test Plan:
- Basic fetch, LATENCY=2: load mem[3]=32'h0000_5601; request addr 32'h0C at edge 0, rsp_ready=1 -> rsp_valid=1 at edge 2, rsp_instr=32'h5601, rsp_err=0, fetch_count=1, req_ready=1 after edge 3.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_instr stable for all 5 cycles, req_ready=0, no further accept. rsp_ready=1 -> single count increment.
- Errors: req_addr=32'h0000_0006 -> rsp_err=1, rsp_instr=0. req_addr=4*DEPTH=32'h1000 -> rsp_err=1, rsp_instr=0.
- Load collision: mem[5]=A; same edge accept addr 32'h14 and ld_we to index 5 with B -> response returns A. Next fetch of 32'h14 returns B.
- Reset mid-op: assert reset=0 asynchronously in WAIT -> rsp_valid=0 immediately, fetch_count=0, no response after release, req_ready=1, mem[3] still 32'h5601.
- Sequential PC stream 0,4,...,60 with rsp_ready=1, LATENCY=1 -> 16 responses in order, each issued 2 cycles apart, fetch_count=16.

Source files
------------

// File: rtl/instr_mem_responder_if.sv
// Fetch-side bus between the fetch unit (master) and the instruction memory
// responder (slave): one request channel and one response channel.
interface instr_mem_responder_if;
  // Both channels transfer on a rising edge where valid & ready are high.
  // Once valid is raised, its payload holds until that transfer. req_ready
  // does not depend on req_valid, and rsp_ready is ignored while rsp_valid=0.
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instr,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_instr,
    output rsp_err
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: word-addressed program store with a loader
// write port and a fixed-latency, single-outstanding fetch read path.
module instr_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_mem_responder_if.slave     fetch,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic [31:0]              fetch_count,
  output logic [1:0]               state_dbg
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT  = 32'(4 * DEPTH);
  localparam logic [1:0]  WAIT_INIT   = (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  wait_q;
  logic [1:0]  wait_d;
  logic [31:0] cap_instr_q;
  logic        cap_err_q;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          rsp_fire;
  logic          req_err;
  logic [AW-1:0] req_idx;

  assign fetch.req_ready = (state_q == S_IDLE) && reset;
  assign accept          = fetch.req_valid && fetch.req_ready;
  assign rsp_fire        = (state_q == S_RESP) && fetch.rsp_ready;

  assign req_idx = fetch.req_addr[AW+1:2];
  assign req_err = (fetch.req_addr[1:0] != 2'b00) || (fetch.req_addr >= ADDR_LIMIT);

  // Program store: never reset, and the loader is locked out while in reset.
  always_ff @(posedge clk) begin
    if (reset && ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = S_RESP;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Data is read at acceptance; a same-edge loader write lands after this read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_instr_q <= 32'h0000_0000;
      cap_err_q   <= 1'b0;
    end else if (accept) begin
      cap_instr_q <= req_err ? 32'h0000_0000 : mem[req_idx];
      cap_err_q   <= req_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= 32'h0000_0000;
    end else if (rsp_fire) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign fetch.rsp_valid = (state_q == S_RESP);
  assign fetch.rsp_instr = (state_q == S_RESP) ? cap_instr_q : 32'h0000_0000;
  assign fetch.rsp_err   = (state_q == S_RESP) ? cap_err_q : 1'b0;
  assign state_dbg       = state_q;

endmodule
